// File: rtl/rw_stage_pipe_pkg.sv
// Shared opcode and load funct3 constants for the register-writeback stage.
// Optional build macro RW_RETIRE_CNT_EN adds retire counting in rw_stage_pipe.
package rw_stage_pipe_pkg;

  localparam logic [6:0] R_type       = 7'b0110011;
  localparam logic [6:0] I_type_alu   = 7'b0010011;
  localparam logic [6:0] I_type_jalr  = 7'b1100111;
  localparam logic [6:0] I_type_ld    = 7'b0000011;
  localparam logic [6:0] J_type       = 7'b1101111;
  localparam logic [6:0] U_type_auipc = 7'b0010111;
  localparam logic [6:0] U_type_lui   = 7'b0110111;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  function automatic logic op_writes(input logic [6:0] op);
    logic w;
    case (op)
      R_type, I_type_alu, I_type_jalr, I_type_ld,
      J_type, U_type_auipc, U_type_lui: w = 1'b1;
      default:                          w = 1'b0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/rw_load_fmt.sv
// Combinational load formatter: selects byte/half/word from the aligned raw word
// and sign- or zero-extends it to XLEN; zero latency, no flow control.
module rw_load_fmt
  import rw_stage_pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] raw,
  input  logic [1:0]      addr_lo,
  input  logic [2:0]      f3,
  output logic [XLEN-1:0] result
);

  logic [31:0] word;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign word = raw[31:0];

  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
  end

  // Halfword loads are assumed aligned, so only addr_lo[1] matters.
  assign half_sel = addr_lo[1] ? word[31:16] : word[15:0];

  always_comb begin
    case (f3)
      F3_LB:   result = XLEN'($signed(byte_sel));
      F3_LH:   result = XLEN'($signed(half_sel));
      F3_LW:   result = XLEN'($signed(word));
      F3_LBU:  result = XLEN'(byte_sel);
      F3_LHU:  result = XLEN'(half_sel);
      default: result = raw;
    endcase
  end

endmodule

// File: rtl/rw_stage_pipe.sv
// Registered writeback stage: 1-cycle latency ma_* -> wb_*, stall holds, flush kills; keeps
// a write history for decode forwarding. RW_RETIRE_CNT_EN adds retire_cnt/retire_pulse.
module rw_stage_pipe
  import rw_stage_pipe_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int RA_W       = 5,
  parameter int HIST_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ma_valid,
  input  logic            stall,
  input  logic            flush,
  input  logic [XLEN-1:0] ma_pc,
  input  logic [XLEN-1:0] ma_aluresult,
  input  logic [31:0]     ma_instruction,
  input  logic [XLEN-1:0] ma_ldresult,
  input  logic [1:0]      ma_addr_lo,
  output logic            wb_en,
  output logic [RA_W-1:0] wb_addr,
  output logic [XLEN-1:0] wb_data,
  input  logic [RA_W-1:0] q_addr,
  output logic            q_hit,
  output logic [XLEN-1:0] q_data
`ifdef RW_RETIRE_CNT_EN
  ,
  output logic [63:0]     retire_cnt,
  output logic            retire_pulse
`endif
);

  logic            valid_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] alu_q;
  logic [31:0]     instr_q;
  logic [XLEN-1:0] ld_q;
  logic [1:0]      addr_lo_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 1'b0;
      pc_q      <= '0;
      alu_q     <= '0;
      instr_q   <= '0;
      ld_q      <= '0;
      addr_lo_q <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (!stall) begin
      valid_q   <= ma_valid;
      pc_q      <= ma_pc;
      alu_q     <= ma_aluresult;
      instr_q   <= ma_instruction;
      ld_q      <= ma_ldresult;
      addr_lo_q <= ma_addr_lo;
    end
  end

  logic [6:0]      opcode;
  logic [4:0]      rd;
  logic [2:0]      f3;
  logic [XLEN-1:0] ld_fmt;
  logic            unused_instr_bits;

  assign opcode            = instr_q[6:0];
  assign rd                = instr_q[11:7];
  assign f3                = instr_q[14:12];
  assign unused_instr_bits = ^instr_q[31:15];

  rw_load_fmt #(.XLEN(XLEN)) u_load_fmt (
    .raw     (ld_q),
    .addr_lo (addr_lo_q),
    .f3      (f3),
    .result  (ld_fmt)
  );

  assign wb_en   = valid_q & op_writes(opcode) & (rd != 5'd0) & ~stall;
  assign wb_addr = RA_W'(rd);

  always_comb begin
    case (opcode)
      I_type_ld:           wb_data = ld_fmt;
      J_type, I_type_jalr: wb_data = pc_q + XLEN'(4);
      default:             wb_data = alu_q;
    endcase
  end

  // Entry 0 is the newest write; an address of 0 marks an empty slot.
  logic [RA_W-1:0] hist_addr [HIST_DEPTH];
  logic [XLEN-1:0] hist_data [HIST_DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < HIST_DEPTH; i++) begin
        hist_addr[i] <= '0;
        hist_data[i] <= '0;
      end
    end else if (wb_en) begin
      hist_addr[0] <= wb_addr;
      hist_data[0] <= wb_data;
      for (int i = 1; i < HIST_DEPTH; i++) begin
        hist_addr[i] <= hist_addr[i-1];
        hist_data[i] <= hist_data[i-1];
      end
    end
  end

  // Walk oldest to newest so younger matches override; the live stage overrides all.
  always_comb begin
    q_hit  = 1'b0;
    q_data = '0;
    for (int i = HIST_DEPTH - 1; i >= 0; i--) begin
      if (hist_addr[i] == q_addr) begin
        q_hit  = 1'b1;
        q_data = hist_data[i];
      end
    end
    if (wb_en && (wb_addr == q_addr)) begin
      q_hit  = 1'b1;
      q_data = wb_data;
    end
    if (q_addr == '0) begin
      q_hit  = 1'b0;
      q_data = '0;
    end
  end

`ifdef RW_RETIRE_CNT_EN
  assign retire_pulse = valid_q & ~stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retire_cnt <= '0;
    end else if (retire_pulse) begin
      retire_cnt <= retire_cnt + 64'd1;
    end
  end
`endif

endmodule

// File: doc/rw_stage_pipe.md
Name: rw_stage_pipe

Overview:
- Parametrised, registered successor of the register-writeback stage in the RISC-V pipeline.
- Captures the memory-access stage bundle into a one-cycle pipeline register.
- Formats load data (byte/half/word, signed/unsigned) and produces the return address for JAL/JALR.
- Keeps a short history of committed writes so the decode stage can forward values.

Parameters:
- XLEN, 32, datapath width; 32 or 64.
- RA_W, 5, register address width.
- HIST_DEPTH, 2, number of committed writes kept for forwarding; minimum 1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- ma_valid  in  1  the memory-access stage bundle is valid.
- stall  in  1  hold the pipeline register.
- flush  in  1  kill the pipeline register contents.
- ma_pc  in  XLEN  PC of the instruction.
- ma_aluresult  in  XLEN  ALU result.
- ma_instruction  in  32  instruction word.
- ma_ldresult  in  XLEN  raw aligned load word.
- ma_addr_lo  in  2  byte offset of the load address.
- wb_en  out  1  register-file write enable.
- wb_addr  out  RA_W  destination register.
- wb_data  out  XLEN  data to write.
- q_addr  in  RA_W  forwarding query register.
- q_hit  out  1  the query matches a pending or recent write.
- q_data  out  XLEN  forwarded value.

Behaviour:
- Reset (async, active-high): pipeline valid, the history, wb_en, wb_addr and wb_data all go to 0. q_hit is 0 while reset is held. Reset asserted mid-operation discards everything immediately.
- Capture rule: on a rising edge, if flush is high, valid <= 0 and the rest of the register is don't-care.
  - Else if stall is high, hold all fields.
  - Else load all ma_* fields and set valid <= ma_valid.
  - flush wins over stall.
- Latency: 1 cycle from the ma_* inputs to wb_*. All wb_* outputs are combinational from the pipeline register.
- Decode (from the registered fields): opcode = instr[6:0], rd = instr[11:7], f3 = instr[14:12].
- Write class: R_type, I_type_alu, I_type_jalr, I_type_ld, J_type, U_type_auipc and U_type_lui write; all other opcodes do not.
- wb_en = valid & writes & (rd != 0) & ~stall. x0 is never written, and no write occurs while stalled.
- Data selection:
  - I_type_ld: format the load result per f3.
    - 000 LB: sign-extend byte[addr_lo].
    - 001 LH: sign-extend the halfword selected by addr_lo[1]; addr_lo[0] is ignored.
    - 010 LW: the full 32-bit word; sign-extended when XLEN=64.
    - 100 LBU / 101 LHU: zero-extend, using the same byte/halfword selection.
    - Any other f3: pass the raw word through.
  - J_type and I_type_jalr: pc + 4, modulo 2^XLEN.
  - All other opcodes: aluresult.
- History:
  - Each cycle with wb_en=1, push {addr, data} into a HIST_DEPTH-entry shift register; the newest entry is at index 0 and the oldest falls off.
  - No push when wb_en=0.
- Forwarding lookup:
  - Priority: the current stage (wb_en & wb_addr==q_addr) first, then history index 0, 1, and so on.
  - q_hit=0 when q_addr==0.
  - On a miss, q_data=0.
- Flush and stall never modify the history.

Optional Feature:
- Macro RW_RETIRE_CNT_EN.
- With the macro defined, two extra outputs are added:
  - retire_cnt (out, 64): counts cycles where valid & ~stall, including non-writing instructions. It is reset to 0 and wraps at 2^64.
  - retire_pulse (out, 1): high in each such cycle.
- Without the macro, neither port nor the counter exists, and behaviour is otherwise identical.

Decomposition:
- Shared package / constants include: the existing opcode defines (R_type, I_type_alu, I_type_jalr, I_type_ld, J_type, U_type_auipc, U_type_lui), plus new LB/LH/LW/LBU/LHU funct3 constants.
- One natural sub-module: rw_load_fmt. It is the combinational load formatter (raw word, addr_lo, f3 -> XLEN result). It is reusable and unit-testable on its own.

Test Plan:
- ADDI rd=5, alu=0x0000_0123, ma_valid=1 -> one cycle later: wb_en=1, wb_addr=5, wb_data=0x123. The history entry 0 then holds reg 5.
- LB with raw=0x80FF_7F01, addr_lo=3 -> wb_data=0xFFFF_FF80. The same access as LBU -> 0x0000_0080. LH with addr_lo=2 -> 0xFFFF_80FF.
- JAL rd=1, pc=0x0000_1000 -> wb_data=0x1004. JALR with rd=0 -> wb_en=0.
- stall=1 and flush=1 in the same cycle -> valid=0, wb_en=0, and the history is unchanged.
- Back-to-back writes to r7 (values 0xA then 0xB) with q_addr=7 -> q_data=0xB. A query of q_addr=0 -> q_hit=0.
- Reset asserted mid-stream without a clock edge -> wb_en=0 and q_hit=0 immediately. With RW_RETIRE_CNT_EN defined, retire_cnt=0.
